block_mac_processor: RTL

BLOCK_MAC_PROCESSOR -- requirements
Module: block_mac_processor

---
 rtl/coproc_pkg.sv | 24 ++
 rtl/row_mac_lane.sv | 28 ++
 rtl/block_mac_processor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
// -----------------------------------------------------------------------------
// coproc_pkg
//   Shared definitions for the block multiply-accumulate coprocessor:
//   FSM state encoding and the default memory region bases.
//   Memory map: A blocks at 0, B blocks at B_BASE, C blocks at C_BASE.
// -----------------------------------------------------------------------------
package coproc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD_C,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    STORE,
    DONE
  } state_t;

  localparam logic [15:0] DEFAULT_A_BASE = 16'h0000;
  localparam logic [15:0] DEFAULT_B_BASE = 16'h4000;
  localparam logic [15:0] DEFAULT_C_BASE = 16'h8000;

endpackage

// File: rtl/row_mac_lane.sv
// -----------------------------------------------------------------------------
// row_mac_lane
//   Combinational scale-and-add of one row: sum[j] = c[j] + a * b[j] for every
//   cell j. Each cell wraps modulo 2^CELL_WIDTH.
// Ports
//   a_cell  : scalar A[i][k]
//   b_row   : B row k, cell j at [j*CELL_WIDTH +: CELL_WIDTH]
//   c_row   : current C row i
//   sum_row : updated C row i
// -----------------------------------------------------------------------------
module row_mac_lane #(
  parameter int SIZE       = 4,
  parameter int CELL_WIDTH = 8
) (
  input  logic [CELL_WIDTH-1:0]      a_cell,
  input  logic [SIZE*CELL_WIDTH-1:0] b_row,
  input  logic [SIZE*CELL_WIDTH-1:0] c_row,
  output logic [SIZE*CELL_WIDTH-1:0] sum_row
);

  // All operands are CELL_WIDTH wide, so the product and sum are evaluated in
  // CELL_WIDTH bits and wrap naturally.
  for (genvar j = 0; j < SIZE; j++) begin : g_cell
    assign sum_row[j*CELL_WIDTH +: CELL_WIDTH] =
      c_row[j*CELL_WIDTH +: CELL_WIDTH] + a_cell * b_row[j*CELL_WIDTH +: CELL_WIDTH];
  end

endmodule

// File: rtl/block_mac_processor.sv
// -----------------------------------------------------------------------------
// block_mac_processor
//   Computes C(r,c) = [C_mem(r,c) +] sum_{x<mu} A(r,x) * B(x,c) on SIZE x SIZE
//   blocks held in a shared, arbitrated memory with 1-cycle read latency.
// Ports
//   in_clk, in_reset           : clock, synchronous active-low reset
//   in_row_index/col_index/mu  : job indices r, c and block count mu
//   in_accumulate              : 1 = add into the C block already in memory
//   in_index_ready/out_index_ack : job handshake (ack pulses on acceptance)
//   out_result_ready           : one-cycle pulse when the job is written back
//   out_request/in_grant       : bus arbitration
//   out_mem_*/in_mem_data      : memory port, row-wide data
// -----------------------------------------------------------------------------
module block_mac_processor
  import coproc_pkg::*;
#(
  parameter int SIZE        = 4,
  parameter int CELL_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] B_BASE = ADDR_WIDTH'(DEFAULT_B_BASE),
  parameter logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(DEFAULT_C_BASE)
) (
  input  logic                         in_clk,
  input  logic                         in_reset,
  input  logic [INDEX_WIDTH-1:0]       in_row_index,
  input  logic [INDEX_WIDTH-1:0]       in_col_index,
  input  logic [INDEX_WIDTH-1:0]       in_mu,
  input  logic                         in_accumulate,
  input  logic                         in_index_ready,
  output logic                         out_index_ack,
  output logic                         out_result_ready,
  output logic                         out_request,
  input  logic                         in_grant,
  output logic                         out_mem_read_en,
  output logic                         out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]        out_mem_address,
  output logic [SIZE*CELL_WIDTH-1:0]   out_mem_data,
  input  logic [SIZE*CELL_WIDTH-1:0]   in_mem_data
);

  localparam int W     = SIZE * CELL_WIDTH;
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] SIZE_A   = ADDR_WIDTH'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] A_BASE   = ADDR_WIDTH'(DEFAULT_A_BASE);

  state_t state, state_next;

  // Latched job
  logic [INDEX_WIDTH-1:0] row_q, col_q, mu_q, x_q;
  logic                   acc_q;

  // Load sequencing: issue_row counts reads issued, pend_row tags the
  // outstanding read so its data lands in the right buffer row.
  logic [ROW_W-1:0] issue_row, pend_row, store_row, i_idx, k_idx;
  logic             issue_all, pending;

  logic [W-1:0] a_buf [SIZE];
  logic [W-1:0] b_buf [SIZE];
  logic [W-1:0] c_buf [SIZE];

  logic                   in_load, read_issue, write_issue, cap_last, step_last;
  logic [INDEX_WIDTH:0]   x_inc;
  logic                   more_blocks;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [W-1:0]           lane_sum;

  assign in_load     = state inside {LOAD_C, LOAD_A, LOAD_B};
  assign read_issue  = in_load && in_grant && !issue_all;
  assign write_issue = (state == STORE) && in_grant;
  assign cap_last    = pending && (pend_row == LAST_ROW);
  assign step_last   = (i_idx == LAST_ROW) && (k_idx == LAST_ROW);
  assign x_inc       = {1'b0, x_q} + 1'b1;
  assign more_blocks = x_inc < {1'b0, mu_q};

  // Row address for the region the current state touches; wraps at ADDR_WIDTH.
  always_comb begin
    logic [ADDR_WIDTH-1:0] r_a, c_a, mu_a, x_a, base, blk;
    logic [ROW_W-1:0]      t;
    // NOTE: every variable assigned in a combinational block gets a default
    // first so no path leaves it holding a value, which would infer a latch.
    r_a  = ADDR_WIDTH'(row_q);
    c_a  = ADDR_WIDTH'(col_q);
    mu_a = ADDR_WIDTH'(mu_q);
    x_a  = ADDR_WIDTH'(x_q);
    t    = (state == STORE) ? store_row : issue_row;
    base = C_BASE;
    blk  = (r_a * mu_a + c_a) * SIZE_A;
    case (state)
      LOAD_A: begin
        base = A_BASE;
        blk  = (r_a * mu_a + x_a) * SIZE_A;
      end
      LOAD_B: begin
        base = B_BASE;
        blk  = (x_a * mu_a + c_a) * SIZE_A;
      end
      default: ;
    endcase
    addr = base + blk + ADDR_WIDTH'(t);
  end

  row_mac_lane #(
    .SIZE       (SIZE),
    .CELL_WIDTH (CELL_WIDTH)
  ) u_lane (
    .a_cell  (a_buf[i_idx][k_idx*CELL_WIDTH +: CELL_WIDTH]),
    .b_row   (b_buf[k_idx]),
    .c_row   (c_buf[i_idx]),
    .sum_row (lane_sum)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge in_clk) begin
    if (!in_reset) state <= IDLE;
    else           state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_index_ready) state_next = REQ;
      REQ:     if (acc_q)          state_next = LOAD_C;
               else if (mu_q == '0) state_next = STORE;
               else                state_next = LOAD_A;
      LOAD_C:  if (cap_last)       state_next = (mu_q == '0) ? STORE : LOAD_A;
      LOAD_A:  if (cap_last)       state_next = LOAD_B;
      LOAD_B:  if (cap_last)       state_next = COMPUTE;
      COMPUTE: if (step_last)      state_next = more_blocks ? LOAD_A : STORE;
      STORE:   if (write_issue && store_row == LAST_ROW) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. The bus is driven to zero whenever no access is issued.
  always_comb begin
    // The ack is gated by reset so a job presented during reset is never acked.
    out_index_ack    = in_reset && (state == IDLE) && in_index_ready;
    out_result_ready = (state == DONE);
    out_request      = in_load || (state == REQ) || (state == STORE);
    out_mem_read_en  = read_issue;
    out_mem_write_en = write_issue;
    out_mem_address  = (read_issue || write_issue) ? addr : '0;
    out_mem_data     = write_issue ? c_buf[store_row] : '0;
  end

  // ---------------------------------------------------------------------------
  // Datapath: job registers, counters and the C accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      row_q     <= '0;
      col_q     <= '0;
      mu_q      <= '0;
      x_q       <= '0;
      acc_q     <= 1'b0;
      issue_row <= '0;
      issue_all <= 1'b0;
      pend_row  <= '0;
      pending   <= 1'b0;  // drops any read outstanding at reset
      store_row <= '0;
      i_idx     <= '0;
      k_idx     <= '0;
      for (int t = 0; t < SIZE; t++) c_buf[t] <= '0;
    end else begin
      pending <= read_issue;
      if (read_issue) begin
        pend_row  <= issue_row;
        issue_row <= issue_row + 1'b1;
        if (issue_row == LAST_ROW) issue_all <= 1'b1;
      end
      if (cap_last) begin
        issue_row <= '0;
        issue_all <= 1'b0;
      end

      case (state)
        IDLE: if (in_index_ready) begin
          row_q <= in_row_index;
          col_q <= in_col_index;
          mu_q  <= in_mu;
          acc_q <= in_accumulate;
          x_q   <= '0;
        end
        REQ: if (!acc_q) begin
          for (int t = 0; t < SIZE; t++) c_buf[t] <= '0;
        end
        LOAD_C: if (pending) c_buf[pend_row] <= in_mem_data;
        COMPUTE: begin
          c_buf[i_idx] <= lane_sum;
          if (k_idx == LAST_ROW) begin
            k_idx <= '0;
            i_idx <= (i_idx == LAST_ROW) ? '0 : i_idx + 1'b1;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
          if (step_last) x_q <= x_inc[INDEX_WIDTH-1:0];
        end
        STORE: if (in_grant) begin
          store_row <= (store_row == LAST_ROW) ? '0 : store_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A and B operand buffers.
  // NOTE: these are pure data storage that is always fully written by a load
  // before COMPUTE reads it, so they carry no reset.
  always_ff @(posedge in_clk) begin
    if (in_reset && pending) begin
      if (state == LOAD_A) a_buf[pend_row] <= in_mem_data;
      if (state == LOAD_B) b_buf[pend_row] <= in_mem_data;
    end
  end

endmodule
